// File: rtl/tpx3_tx_pkg.sv
// Shared definitions for the Timepix3 serial-output emulator.
//   K28_5_RDN / K28_5_RDP : comma code groups for negative / positive running disparity
//   PACKET_BYTES          : bytes per 48-bit pixel packet
//   tx_state_e            : transmitter FSM state encoding
package tpx3_tx_pkg;

  localparam logic [9:0]  K28_5_RDN    = 10'b0011111010;
  localparam logic [9:0]  K28_5_RDP    = 10'b1100000101;
  localparam int unsigned PACKET_BYTES = 6;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_IDLE = 2'd1,
    ST_SEND = 2'd2
  } tx_state_e;

endpackage

// File: rtl/encode_8b10b.sv
// Combinational 8b/10b encoder.
//   data_i : byte HGF_EDCBA (x = EDCBA, y = HGF)
//   k_i    : emit the comma K28.5 instead of a data character (data_i ignored)
//   rd_i   : running disparity in (0 = negative, 1 = positive)
//   code_o : code group {a,b,c,d,e,i,f,g,h,j}, bit 9 = a
//   rd_o   : running disparity after this code group
module encode_8b10b
  import tpx3_tx_pkg::*;
(
  input  logic [7:0] data_i,
  input  logic       k_i,
  input  logic       rd_i,
  output logic [9:0] code_o,
  output logic       rd_o
);

  logic [4:0] x;
  logic [2:0] y;
  logic [5:0] t6;
  logic [5:0] c6;
  logic [3:0] t4;
  logic [3:0] c4;
  logic       rd_mid;
  logic       unbal6;
  logic       unbal4;
  logic       alt7;

  assign x = data_i[4:0];
  assign y = data_i[7:5];

  // 5b/6b table, RD- column
  always_comb begin
    case (x)
      5'd0:    t6 = 6'b100111;
      5'd1:    t6 = 6'b011101;
      5'd2:    t6 = 6'b101101;
      5'd3:    t6 = 6'b110001;
      5'd4:    t6 = 6'b110101;
      5'd5:    t6 = 6'b101001;
      5'd6:    t6 = 6'b011001;
      5'd7:    t6 = 6'b111000;
      5'd8:    t6 = 6'b111001;
      5'd9:    t6 = 6'b100101;
      5'd10:   t6 = 6'b010101;
      5'd11:   t6 = 6'b110100;
      5'd12:   t6 = 6'b001101;
      5'd13:   t6 = 6'b101100;
      5'd14:   t6 = 6'b011100;
      5'd15:   t6 = 6'b010111;
      5'd16:   t6 = 6'b011011;
      5'd17:   t6 = 6'b100011;
      5'd18:   t6 = 6'b010011;
      5'd19:   t6 = 6'b110010;
      5'd20:   t6 = 6'b001011;
      5'd21:   t6 = 6'b101010;
      5'd22:   t6 = 6'b011010;
      5'd23:   t6 = 6'b111010;
      5'd24:   t6 = 6'b110011;
      5'd25:   t6 = 6'b100110;
      5'd26:   t6 = 6'b010110;
      5'd27:   t6 = 6'b110110;
      5'd28:   t6 = 6'b001110;
      5'd29:   t6 = 6'b101110;
      5'd30:   t6 = 6'b011110;
      default: t6 = 6'b101011;
    endcase
  end

  // Unbalanced groups (and the balanced-but-polar D.7) are inverted under RD+.
  always_comb begin
    unbal6 = ($countones(t6) != 3);
    c6     = (rd_i && (unbal6 || (x == 5'd7))) ? ~t6 : t6;
    rd_mid = rd_i ^ unbal6;
  end

  // D.x.A7 avoids a run of five equal bits across the sub-block boundary.
  assign alt7 = (y == 3'd7) &&
                ((!rd_mid && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
                 ( rd_mid && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))));

  // 3b/4b table, RD- column
  always_comb begin
    case (y)
      3'd0:    t4 = 4'b1011;
      3'd1:    t4 = 4'b1001;
      3'd2:    t4 = 4'b0101;
      3'd3:    t4 = 4'b1100;
      3'd4:    t4 = 4'b1101;
      3'd5:    t4 = 4'b1010;
      3'd6:    t4 = 4'b0110;
      default: t4 = alt7 ? 4'b0111 : 4'b1110;
    endcase
  end

  always_comb begin
    unbal4 = ($countones(t4) != 2);
    c4     = (rd_mid && ((y == 3'd0) || (y == 3'd3) || (y == 3'd4) || (y == 3'd7))) ? ~t4 : t4;
  end

  always_comb begin
    if (k_i) begin
      code_o = rd_i ? K28_5_RDP : K28_5_RDN;
      rd_o   = ~rd_i;
    end else begin
      code_o = {c6, c4};
      rd_o   = rd_mid ^ unbal4;
    end
  end

endmodule

// File: rtl/tpx3_tx_emu.sv
// Timepix3 serial data output emulator: sends a K28.5 preamble, then 8b/10b
// encodes 48-bit packets (MSB byte first), one registered code group per clock,
// with K28.5 fill whenever no packet is in flight.
//   clk_i          : word clock, one symbol per cycle
//   rst_i          : asynchronous active-high reset
//   enable_i       : transmitter enable
//   data_in_i      : packet, [47:40] sent first
//   data_valid_i   : packet available
//   data_ready_o   : packet taken when data_valid_i && data_ready_o
//   tx_symbol_o    : code group, bit 9 transmitted first
//   tx_k_o         : tx_symbol_o is a K character
//   tx_synced_o    : preamble complete (IDLE or SEND)
//   busy_o         : packet in flight
//   packet_cnt_o   : fully transmitted packets, wrapping
// SYNC_COMMAS must be even (>= 2) so the preamble leaves RD negative.
module tpx3_tx_emu
  import tpx3_tx_pkg::*;
#(
  parameter int unsigned SYNC_COMMAS = 16,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic [47:0]          data_in_i,
  input  logic                 data_valid_i,
  output logic                 data_ready_o,
  output logic [9:0]           tx_symbol_o,
  output logic                 tx_k_o,
  output logic                 tx_synced_o,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] packet_cnt_o
);

  localparam int unsigned    CW         = $clog2(SYNC_COMMAS);
  localparam logic [CW-1:0]  COMMA_LAST = CW'(SYNC_COMMAS - 1);
  localparam logic [2:0]     BYTE_LAST  = 3'(PACKET_BYTES - 1);

  tx_state_e            state_q;
  logic [CW-1:0]        comma_cnt_q;
  logic [2:0]           byte_idx_q;
  logic [47:0]          shift_q;
  logic [9:0]           sym_q;
  logic                 k_q;
  logic                 rd_q;
  logic                 synced_q;
  logic                 busy_q;
  logic [CNT_WIDTH-1:0] pkt_cnt_q;

  logic                 last_byte;
  logic                 hs;
  logic [9:0]           enc_code;
  logic                 enc_rd;

  assign last_byte = (state_q == ST_SEND) && (byte_idx_q == BYTE_LAST);

  // Ready is combinational so a packet can be taken in the final byte slot
  // and follow on without a comma gap.
  assign data_ready_o = enable_i && ((state_q == ST_IDLE) || last_byte);
  assign hs           = data_ready_o && data_valid_i;

  encode_8b10b u_enc (
    .data_i (shift_q[47:40]),
    .k_i    (state_q != ST_SEND),
    .rd_i   (rd_q),
    .code_o (enc_code),
    .rd_o   (enc_rd)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_SYNC;
      comma_cnt_q <= '0;
      byte_idx_q  <= '0;
      shift_q     <= '0;
      sym_q       <= K28_5_RDN;
      k_q         <= 1'b1;
      rd_q        <= 1'b0;
      synced_q    <= 1'b0;
      busy_q      <= 1'b0;
      pkt_cnt_q   <= '0;
    end else begin
      sym_q <= enc_code;
      k_q   <= (state_q != ST_SEND);
      rd_q  <= enc_rd;
      case (state_q)
        ST_SYNC: begin
          if (!enable_i) begin
            comma_cnt_q <= '0;
          end else if (comma_cnt_q == COMMA_LAST) begin
            comma_cnt_q <= '0;
            state_q     <= ST_IDLE;
            synced_q    <= 1'b1;
          end else begin
            comma_cnt_q <= comma_cnt_q + 1'b1;
          end
        end
        ST_IDLE: begin
          if (!enable_i) begin
            state_q  <= ST_SYNC;
            synced_q <= 1'b0;
          end else if (hs) begin
            shift_q    <= data_in_i;
            byte_idx_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= ST_SEND;
          end
        end
        ST_SEND: begin
          shift_q    <= {shift_q[39:0], 8'h00};
          byte_idx_q <= byte_idx_q + 3'd1;
          if (last_byte) begin
            pkt_cnt_q  <= pkt_cnt_q + 1'b1;
            byte_idx_q <= '0;
            if (hs) begin
              shift_q <= data_in_i;
            end else begin
              busy_q <= 1'b0;
              if (enable_i) begin
                state_q <= ST_IDLE;
              end else begin
                state_q  <= ST_SYNC;
                synced_q <= 1'b0;
              end
            end
          end
        end
        default: begin
          state_q  <= ST_SYNC;
          synced_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign tx_symbol_o  = sym_q;
  assign tx_k_o       = k_q;
  assign tx_synced_o  = synced_q;
  assign busy_o       = busy_q;
  assign packet_cnt_o = pkt_cnt_q;

endmodule

// File: doc/tpx3_tx_emu.md
Name: tpx3_tx_emu

Overview:
- Emulates the Timepix3 serial data output for the tpx3_rx receiver path: accepts 48-bit pixel packets, 8b10b-encodes them and emits one 10-bit symbol per clock.
- Sends K28.5 commas at start-up and whenever idle.
- An external serializer shifts TX_SYMBOL out MSB first.
- Used for loop-back testing of the receiver, decoder, arbiter and FIFO chain without a chip.

Parameters:
- SYNC_COMMAS, 16, number of K28.5 symbols sent after reset or enable before data is accepted; must be even, minimum 2.
- CNT_WIDTH, 16, width of PACKET_CNT.

Ports:
- CLK  input  1  word clock; one symbol per cycle.
- RST  input  1  asynchronous, active-high reset.
- ENABLE  input  1  transmitter enable.
- DATA_IN  input  48  packet; bits [47:40] are sent first.
- DATA_VALID  input  1  packet available.
- DATA_READY  output  1  packet accepted on a cycle where DATA_VALID and DATA_READY are both high.
- TX_SYMBOL  output  10  registered code group {a,b,c,d,e,i,f,g,h,j}; bit 9 (a) is transmitted first.
- TX_K  output  1  TX_SYMBOL is a K character.
- TX_SYNCED  output  1  the SYNC_COMMAS preamble has completed.
- BUSY  output  1  a packet is in flight.
- PACKET_CNT  output  CNT_WIDTH  count of fully transmitted packets; wraps.

Behaviour:
- Reset values:
  - TX_SYMBOL = 10'b0011111010 (K28.5, RD-).
  - TX_K = 1.
  - Running disparity RD = negative.
  - DATA_READY, BUSY, TX_SYNCED = 0.
  - PACKET_CNT = 0.
  - State = SYNC, comma counter = 0.
- States:
  - SYNC:
    - Send K28.5 each cycle and increment the comma counter.
    - When the counter reaches SYNC_COMMAS-1, go to IDLE.
    - If ENABLE=0, hold the counter at 0.
  - IDLE:
    - Send K28.5.
    - DATA_READY = ENABLE.
    - On handshake, latch DATA_IN, go to SEND with byte index = 0 and BUSY = 1.
  - SEND:
    - Encode byte[index] (index 0 = DATA_IN[47:40] … index 5 = [7:0]) as Dx.y and increment index.
    - At index 5, increment PACKET_CNT.
    - DATA_READY = ENABLE during the index-5 cycle; a handshake there latches the next packet and restarts at index 0 with no comma gap.
    - Otherwise go to IDLE.
- TX_SYNCED = 1 in IDLE and SEND.
- ENABLE deasserted:
  - In SEND, the current packet completes.
  - The block then returns to SYNC with the counter cleared, so a fresh preamble is sent on re-enable.
  - TX_SYNCED drops to 0 in the same cycle as the transition into SYNC.
- Latency:
  - Symbol selection and encoding are combinational from state.
  - TX_SYMBOL, TX_K and RD are registered.
  - For a handshake at edge E0, byte 0 appears after E1 and byte 5 after E6.
- 8b10b encoding:
  - Standard 5b/6b and 3b/4b tables, with the RD update per sub-block.
  - Uses the D.x.A7 alternate encoding where the standard requires it (x = 17, 18, 20 with RD-; x = 11, 13, 14 with RD+).
  - K28.5 is chosen by current RD: RD- gives 0011111010, RD+ gives 1100000101; K28.5 flips RD.
  - Even SYNC_COMMAS therefore leaves RD negative.
- The output must decode error-free and comma-align in tpx3_rx's decode_8b10b with the same bit order.
- Asynchronous reset mid-packet aborts immediately; the remaining bytes are discarded and not counted.
- DATA_IN is sampled only at handshake; changes while BUSY have no effect.
- PACKET_CNT wraps from 2^CNT_WIDTH-1 to 0.

Decomposition:
- Package tpx3_tx_pkg holds:
  - K28_5_RDN / K28_5_RDP constants.
  - State encoding (SYNC, IDLE, SEND).
  - PACKET_BYTES = 6.
- One natural sub-module: encode_8b10b.
  - Inputs: 8-bit data, K flag, RD in.
  - Outputs: 10-bit code, RD out.
  - Purely combinational; reusable by other emulators.

Test Plan:
- Reset then ENABLE=1, DATA_VALID=0 -> 16 symbols alternating 0011111010 / 1100000101 with TX_K=1, then TX_SYNCED=1 and DATA_READY=1; RD negative at IDLE entry.
- Packet 48'h000000000000 after sync -> six symbols 1001110100 (D0.0 RD-), TX_K=0, RD stays negative, PACKET_CNT=1, then K28.5 RD- resumes.
- Two packets presented back-to-back (DATA_VALID held high) -> 12 data symbols with no intervening comma; DATA_READY pulses in the index-5 cycles; PACKET_CNT=2.
- Random packets looped through tpx3_rx decode_8b10b -> zero decoder or disparity errors and received bytes equal to the sent bytes in order; covers D.x.A7 cases (e.g. byte 0xF1 under RD-).
- ENABLE dropped at byte 2 -> bytes 3–5 still sent, PACKET_CNT increments, TX_SYNCED=0; on re-enable, 16 commas precede the next DATA_READY.
- RST asserted at byte 3 -> TX_SYMBOL=0011111010 immediately (asynchronous), PACKET_CNT=0, state=SYNC, no partial packet counted.
